// File: rtl/lane_pkg.sv
// Shared types for the bidirectional lane controller.
package lane_pkg;

  localparam int unsigned NbLanesDef   = 3;
  localparam int unsigned DataWidthDef = 16;

  // One full-width lane word at the default geometry.
  typedef logic [NbLanesDef-1:0][DataWidthDef-1:0] lane_word_t;

  // Bus ownership: RX (external drives), TX (we drive), two idle turnaround states.
  typedef enum logic [1:0] {
    StRx     = 2'd0,
    StTurnTx = 2'd1,
    StTx     = 2'd2,
    StTurnRx = 2'd3
  } lane_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, simultaneous push/pop, show-ahead read port.
module sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [Width-1:0] mem_q [Depth];
  logic push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bidir_lane_ctrl.sv
// Direction/turnaround controller for NB_LANES bidirectional lanes with an outbound FIFO
// and a saturating transferred-bit counter.
module bidir_lane_ctrl
  import lane_pkg::*;
#(
  parameter int unsigned NB_LANES       = 3,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned OUT_FIFO_DEPTH = 4,
  parameter int unsigned TURNAROUND     = 1,
  parameter int unsigned CNT_WIDTH      = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NB_LANES*DATA_WIDTH-1:0] lane_in,
  output logic [NB_LANES*DATA_WIDTH-1:0] lane_out,
  output logic                           lane_oe,
  input  logic                           con_valid,
  output logic                           con_ready,
  output logic [NB_LANES*DATA_WIDTH-1:0] in_data,
  output logic                           in_valid,
  input  logic                           in_ready,
  input  logic [NB_LANES*DATA_WIDTH-1:0] out_data,
  input  logic                           out_valid,
  output logic                           out_ready,
  output logic                           out_strobe,
  input  logic                           cnt_clear,
  output logic [CNT_WIDTH-1:0]           bit_count
);

  localparam int unsigned WordW = NB_LANES * DATA_WIDTH;
  localparam int unsigned TaW   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_WIDTH:0] Inc = (CNT_WIDTH+1)'(WordW);

  lane_state_e          state_q;
  logic [TaW-1:0]       turn_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [WordW-1:0]     fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 in_xfer;

  sync_fifo #(
    .Depth (OUT_FIFO_DEPTH),
    .Width (WordW)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (out_valid),
    .wdata_i (out_data),
    .pop_i   (out_strobe),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Inbound handshake is a pure pass-through while we listen; masked during reset.
  assign con_ready  = (state_q == StRx) && in_ready && !rst;
  assign in_valid   = (state_q == StRx) && con_valid && !rst;
  assign in_data    = lane_in;
  assign in_xfer    = con_valid && con_ready;
  assign lane_oe    = (state_q == StTx);
  assign out_strobe = lane_oe && !fifo_empty;
  assign lane_out   = lane_oe ? fifo_head : '0;
  assign out_ready  = !fifo_full;
  assign bit_count  = cnt_q;

  // Direction FSM; turnaround counter loads on leaving RX/TX and counts down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRx;
      turn_q  <= '0;
    end else begin
      unique case (state_q)
        StRx: begin
          // A live inbound handshake keeps the bus in RX.
          if (!fifo_empty && !in_xfer) begin
            state_q <= StTurnTx;
            turn_q  <= TaW'(TURNAROUND - 1);
          end
        end
        StTurnTx: begin
          if (turn_q == '0) state_q <= StTx;
          else              turn_q  <= turn_q - TaW'(1);
        end
        StTx: begin
          if (fifo_empty) begin
            state_q <= StTurnRx;
            turn_q  <= TaW'(TURNAROUND - 1);
          end
        end
        StTurnRx: begin
          if (turn_q == '0) state_q <= StRx;
          else              turn_q  <= turn_q - TaW'(1);
        end
        default: state_q <= StRx;
      endcase
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + Inc;

  // Saturating bit counter; clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (in_xfer || out_strobe) begin
      cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_bidir_lane_ctrl.sv
// Scoreboard bench for bidir_lane_ctrl (3 lanes x 16 bits, TURNAROUND=1) plus an 8-bit
// counter instance sharing the same stimulus for the saturation case.
module tb_bidir_lane_ctrl;
  import lane_pkg::*;

  localparam int W = 48;

  logic clk = 1'b0;
  logic rst, con_valid, in_ready, out_valid, cnt_clear;
  lane_word_t lane_in;
  logic [W-1:0] out_data;

  logic [W-1:0] lane_out, in_data;
  logic lane_oe, con_ready, in_valid, out_ready, out_strobe;
  logic [47:0] bit_count;

  logic [W-1:0] s_lane_out, s_in_data;
  logic s_lane_oe, s_con_ready, s_in_valid, s_out_ready, s_out_strobe;
  logic [7:0] s_bit_count;

  bidir_lane_ctrl dut (
    .clk(clk), .rst(rst), .lane_in(lane_in), .lane_out(lane_out), .lane_oe(lane_oe),
    .con_valid(con_valid), .con_ready(con_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_strobe(out_strobe), .cnt_clear(cnt_clear), .bit_count(bit_count)
  );

  bidir_lane_ctrl #(.CNT_WIDTH(8)) dut_sat (
    .clk(clk), .rst(rst), .lane_in(lane_in), .lane_out(s_lane_out), .lane_oe(s_lane_oe),
    .con_valid(con_valid), .con_ready(s_con_ready), .in_data(s_in_data),
    .in_valid(s_in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(s_out_ready), .out_strobe(s_out_strobe), .cnt_clear(cnt_clear),
    .bit_count(s_bit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic       oe_log [4096];
  logic       str_log[4096];
  logic       cr_log [4096];
  logic       or_log [4096];
  logic [1:0] st_log [4096];
  logic [W-1:0] mon_e;

  // Per-cycle monitor: log observables, check invariants, pop scoreboards on transfers.
  always @(negedge clk) begin
    if (cyc_n < 4096) begin
      oe_log[cyc_n]  <= lane_oe;
      str_log[cyc_n] <= out_strobe;
      cr_log[cyc_n]  <= con_ready;
      or_log[cyc_n]  <= out_ready;
      st_log[cyc_n]  <= dut.state_q;
    end
    check_val("excl", 64'((lane_oe | out_strobe) & (in_valid | con_ready)), 0);
    check_val("excl_sat", 64'((s_lane_oe | s_out_strobe) & (s_in_valid | s_con_ready)), 0);
    if (!lane_oe)   check_val("lane_out_idle", lane_out, 0);
    if (!s_lane_oe) check_val("lane_out_idle_sat", s_lane_out, 0);
    if (con_valid && con_ready) begin
      if (in_q.size() == 0) begin
        check_val("in_unexpected", in_data, '1);
      end else begin
        mon_e = in_q.pop_front();
        check_val("in_data", in_data, mon_e);
        check_val("in_valid", in_valid, 1);
      end
    end
    if (out_strobe) begin
      if (out_q.size() == 0) begin
        check_val("strobe_unexpected", lane_out, '1);
      end else begin
        mon_e = out_q.pop_front();
        check_val("lane_out", lane_out, mon_e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_in(input logic [W-1:0] w);
    lane_in   = w;
    con_valid = 1'b1;
    in_q.push_back(w);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (con_ready) begin
        cyc();
        con_valid = 1'b0;
        return;
      end
      cyc();
    end
    check_val("send_in_timeout", con_ready, 1);
    con_valid = 1'b0;
  endtask

  task automatic push_out(input logic [W-1:0] w, output int acc);
    out_data  = w;
    out_valid = 1'b1;
    acc       = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_ready) begin
        out_q.push_back(w);
        acc = cyc_n;
        cyc();
        out_valid = 1'b0;
        return;
      end
      cyc();
    end
    check_val("push_out_timeout", out_ready, 1);
    out_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int t0, tmp, c0;
  int acc[5];
  logic [W-1:0] in_pat[4];
  logic [W-1:0] dw[5];

  initial begin
    in_pat[0] = 48'h0001_0002_0003;
    in_pat[1] = 48'hFFFF_0000_FFFF;
    in_pat[2] = 48'hA5A5_5A5A_1234;
    in_pat[3] = 48'h8000_0001_7FFE;
    dw[0] = 48'hD000_0000_0001; dw[1] = 48'hD000_0000_0002; dw[2] = 48'hD000_0000_0003;
    dw[3] = 48'hD000_0000_0004; dw[4] = 48'hD000_0000_0005;

    // Reset, with the external side trying to handshake.
    rst = 1'b1; con_valid = 1'b1; in_ready = 1'b1; out_valid = 1'b0; cnt_clear = 1'b0;
    lane_in = 48'h1234_5678_9ABC; out_data = '0;
    repeat (2) cyc();
    @(negedge clk);
    check_val("rst_lane_oe", lane_oe, 0);
    check_val("rst_lane_out", lane_out, 0);
    check_val("rst_con_ready", con_ready, 0);
    check_val("rst_in_valid", in_valid, 0);
    check_val("rst_out_strobe", out_strobe, 0);
    check_val("rst_bit_count", bit_count, 0);
    cyc();
    rst = 1'b0; con_valid = 1'b0;
    @(negedge clk);
    check_val("post_rst_out_ready", out_ready, 1);
    check_val("post_rst_state", dut.state_q, StRx);
    check_val("post_rst_con_ready", con_ready, 1);
    cyc();

    // Inbound stream of four words.
    for (int i = 0; i < 4; i++) send_in(in_pat[i]);
    @(negedge clk);
    check_val("in_bits_192", bit_count, 192);
    check_val("in_q_drained", in_q.size(), 0);
    cyc();
    in_ready = 1'b0; con_valid = 1'b1; lane_in = 48'hBAD0_BAD0_BAD0;
    @(negedge clk);
    check_val("stall_con_ready", con_ready, 0);
    check_val("stall_in_valid", in_valid, 1);
    cyc();
    con_valid = 1'b0; in_ready = 1'b1;
    @(negedge clk);
    check_val("stall_bits_hold", bit_count, 192);
    cyc();
    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    @(negedge clk);
    check_val("clear_bits", bit_count, 0);
    cyc();

    // Outbound burst from idle RX.
    push_out(48'h1111, t0);
    push_out(48'h2222, tmp);
    push_out(48'h3333, tmp);
    repeat (8) cyc();
    check_val("burst_t1_oe", oe_log[t0+1], 0);
    check_val("turn_tx_oe", oe_log[t0+2], 0);
    check_val("turn_tx_cr", cr_log[t0+2], 0);
    for (int k = 3; k <= 5; k++) check_val("burst_strobe", str_log[t0+k], 1);
    check_val("tx_empty_strobe", str_log[t0+6], 0);
    check_val("tx_empty_oe", oe_log[t0+6], 1);
    check_val("turn_rx_oe", oe_log[t0+7], 0);
    check_val("turn_rx_cr", cr_log[t0+7], 0);
    check_val("back_rx_cr", cr_log[t0+8], 1);
    @(negedge clk);
    check_val("burst_bits_144", bit_count, 144);
    check_val("burst_out_q", out_q.size(), 0);
    cyc();

    // Contention: inbound traffic holds the bus in RX while the FIFO waits.
    c0 = cyc_n;
    fork
      push_out(48'hC0C0_C0C0_C0C0, tmp);
      for (int i = 0; i < 6; i++) send_in(48'h0100_0000_0000 + 48'(i));
    join
    repeat (6) cyc();
    for (int k = 0; k <= 6; k++) check_val("contend_rx", st_log[c0+k], StRx);
    check_val("contend_no_early", str_log[c0+7], 0);
    check_val("contend_strobe", str_log[c0+8], 1);
    check_val("contend_out_q", out_q.size(), 0);

    // FIFO full: five pushes while RX is kept busy.
    fork
      for (int i = 0; i < 5; i++) push_out(dw[i], acc[i]);
      for (int i = 0; i < 6; i++) send_in(48'h0200_0000_0000 + 48'(i));
    join
    repeat (10) cyc();
    check_val("full_after_4", or_log[acc[3]+1], 0);
    check_val("push5_cycle", acc[4], acc[0] + 9);
    check_val("push5_in_tx", oe_log[acc[4]], 1);
    check_val("full_out_q", out_q.size(), 0);

    // Reset asserted during the second strobe of a burst.
    push_out(48'hE1, t0);
    push_out(48'hE2, tmp);
    push_out(48'hE3, tmp);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_tx_2nd_strobe", str_log[t0+4], 1);
    check_val("rst_tx_oe", lane_oe, 0);
    check_val("rst_tx_state", dut.state_q, StRx);
    check_val("rst_tx_fifo_empty", dut.u_out_fifo.empty_o, 1);
    check_val("rst_tx_bits", bit_count, 0);
    out_q.delete();
    repeat (4) cyc();
    check_val("rst_tx_no_resume", oe_log[t0+7], 0);

    // Saturation on the 8-bit instance, then clear racing a transfer.
    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    for (int i = 0; i < 6; i++) send_in(48'h0300_0000_0000 + 48'(i));
    @(negedge clk);
    check_val("sat_255", s_bit_count, 255);
    check_val("nosat_288", bit_count, 288);
    cyc();
    cnt_clear = 1'b1;
    send_in(48'h0400_0000_0000);
    cnt_clear = 1'b0;
    @(negedge clk);
    check_val("clear_prio", bit_count, 0);
    check_val("clear_prio_sat", s_bit_count, 0);
    check_val("final_in_q", in_q.size(), 0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
